// File: rtl/pipe_scroller_if.sv
// Pipe-pattern interface between the pipe generator / game controller (master)
// and the playfield scroller (slave).
interface pipe_scroller_if #(
  parameter int SCORE_W = 8
);
  // start and tick are single-cycle strobes. pipe_in must be stable in the cycle
  // a tick is taken in INSERT. pipe_req is a single-cycle request, raised the
  // cycle after a column was inserted, for the next pattern. No backpressure.
  logic                start;
  logic                tick;
  logic [3:0]          bird_row;
  logic [15:0][15:0]   pipe_in;
  logic                pipe_req;
  logic [15:0][15:0]   field;
  logic [3:0]          gap_row;
  logic                gap_valid;
  logic                collision;
  logic [SCORE_W-1:0]  score;
  logic [1:0]          state;

  modport master (
    output start, tick, bird_row, pipe_in,
    input  pipe_req, field, gap_row, gap_valid, collision, score, state
  );

  modport slave (
    input  start, tick, bird_row, pipe_in,
    output pipe_req, field, gap_row, gap_valid, collision, score, state
  );
endinterface

// File: rtl/pipe_scroller.sv
// Scrolls the 16x16 playfield one column left per tick, inserting a pipe column
// every SPACING+1 ticks; tracks bird collisions and the pipes-passed score.
module pipe_scroller #(
  parameter int SPACING  = 4,
  parameter int BIRD_COL = 12,
  parameter int SCORE_W  = 8
) (
  input  logic           clk,
  input  logic           reset,
  pipe_scroller_if.slave pif
);
  localparam int CW = $clog2(SPACING + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GAP    = 2'd1,
    INSERT = 2'd2,
    OVER   = 2'd3
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      gap_cnt;
  logic [15:0][15:0]  field_q;
  logic [15:0][15:0]  field_nx;
  logic [SCORE_W-1:0] score_q;
  logic               coll_q;
  logic               req_q;
  logic [15:0]        col;
  logic [3:0]         gap_row;
  logic               found;
  logic               run;
  logic               hit;

  // Shifted field: only bit 0 of each generator row is ever consumed.
  always_comb begin
    col      = '0;
    field_nx = '0;
    for (int r = 0; r < 16; r++) begin
      col[r]      = field_q[r][BIRD_COL];
      field_nx[r] = {field_q[r][14:0], (state_q == INSERT) ? pif.pipe_in[r][0] : 1'b0};
    end
  end

  always_comb begin
    gap_row = '0;
    found   = 1'b0;
    for (int r = 0; r < 16; r++) begin
      if (!found && !col[r]) begin
        gap_row = 4'(r);
        found   = 1'b1;
      end
    end
    if (col == '0) gap_row = '0;
  end

  assign run = (state_q == GAP) || (state_q == INSERT);
  assign hit = field_q[pif.bird_row][BIRD_COL];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gap_cnt <= '0;
      field_q <= '0;
      score_q <= '0;
      coll_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      req_q <= 1'b0;
      if (pif.start) begin
        field_q <= '0;
        score_q <= '0;
        coll_q  <= 1'b0;
        gap_cnt <= CW'(SPACING);
        state_q <= GAP;
      end else if (run) begin
        // A hit freezes the field: any coincident tick is dropped.
        if (hit) begin
          coll_q  <= 1'b1;
          state_q <= OVER;
        end else if (pif.tick) begin
          field_q <= field_nx;
          if ((col != '0) && (score_q != SCORE_MAX)) score_q <= score_q + SCORE_W'(1);
          if (state_q == INSERT) begin
            gap_cnt <= CW'(SPACING);
            state_q <= GAP;
            req_q   <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - CW'(1);
            if (gap_cnt == CW'(1)) state_q <= INSERT;
          end
        end
      end
    end
  end

  assign pif.field     = field_q;
  assign pif.score     = score_q;
  assign pif.collision = coll_q;
  assign pif.pipe_req  = req_q;
  assign pif.state     = state_q;
  assign pif.gap_row   = gap_row;
  assign pif.gap_valid = (col != '0);
endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller: a default instance and a SCORE_W=2 instance
// share stimulus; a negedge monitor pops queued expectations and compares.
module tb_pipe_scroller;
  localparam logic [1:0]  S_IDLE = 2'd0, S_GAP = 2'd1, S_INS = 2'd2, S_OVER = 2'd3;
  localparam logic [15:0] P = 16'hFF0F;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, tick;
  logic [3:0]       bird_row;
  logic [15:0][15:0] pipe_in;

  always #5 clk = ~clk;

  pipe_scroller_if #(.SCORE_W(8)) ifa ();
  pipe_scroller_if #(.SCORE_W(2)) ifb ();

  assign ifa.start = start;    assign ifb.start = start;
  assign ifa.tick = tick;      assign ifb.tick = tick;
  assign ifa.bird_row = bird_row; assign ifb.bird_row = bird_row;
  assign ifa.pipe_in = pipe_in;   assign ifb.pipe_in = pipe_in;

  pipe_scroller #(.SPACING(4), .BIRD_COL(12), .SCORE_W(8)) dut (
    .clk(clk), .reset(reset), .pif(ifa.slave)
  );
  pipe_scroller #(.SPACING(4), .BIRD_COL(12), .SCORE_W(2)) dut2 (
    .clk(clk), .reset(reset), .pif(ifb.slave)
  );

  typedef struct {
    string       name;
    logic [15:0] pat;
    logic [15:0] mask;
    logic [1:0]  state;
    logic        coll;
    logic [7:0]  score;
    logic [1:0]  score2;
    logic        gv;
    logic [3:0]  gr;
  } exp_t;

  exp_t exp_q[$];
  int   req_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t mon_e;
  int   mon_c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [255:0] mk_field(input logic [15:0] pat, input logic [15:0] mask);
    logic [15:0][15:0] f;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        f[r][c] = pat[r] & mask[c];
    return f;
  endfunction

  // Monitor: one expectation record per pushed cycle, plus pipe_req timing.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      cmp({mon_e.name, " field"}, ifa.field, mk_field(mon_e.pat, mon_e.mask));
      cmp({mon_e.name, " field2"}, ifb.field, mk_field(mon_e.pat, mon_e.mask));
      cmp({mon_e.name, " state"}, ifa.state, mon_e.state);
      cmp({mon_e.name, " collision"}, ifa.collision, mon_e.coll);
      cmp({mon_e.name, " score"}, ifa.score, mon_e.score);
      cmp({mon_e.name, " score_w2"}, ifb.score, mon_e.score2);
      cmp({mon_e.name, " gap_valid"}, ifa.gap_valid, mon_e.gv);
      cmp({mon_e.name, " gap_row"}, ifa.gap_row, mon_e.gr);
    end
    if (ifa.pipe_req === 1'b1) begin
      if (req_q.size() == 0) cmp("pipe_req unexpected", 1, 0);
      else begin
        mon_c = req_q.pop_front();
        cmp("pipe_req cycle", cyc, mon_c);
      end
    end else if (req_q.size() != 0 && req_q[0] <= cyc) begin
      mon_c = req_q.pop_front();
      cmp("pipe_req missing", 0, 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input logic [15:0] pat, input logic [15:0] mask,
                      input logic [1:0] st, input logic coll, input logic [7:0] sc,
                      input logic [1:0] sc2, input logic gv, input logic [3:0] gr);
    exp_t e;
    e.name = name; e.pat = pat; e.mask = mask; e.state = st; e.coll = coll;
    e.score = sc; e.score2 = sc2; e.gv = gv; e.gr = gr;
    exp_q.push_back(e);
  endtask

  task automatic set_pat(input logic [15:0] pat);
    logic [15:0] w;
    for (int r = 0; r < 16; r++) begin
      w = 16'($urandom_range(0, 65535));
      w[0] = pat[r];
      pipe_in[r] = w;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // ins: this tick is the insertion tick, so pipe_req is due right after it.
  task automatic do_tick(input bit ins);
    tick = 1'b1;
    step();
    tick = 1'b0;
    if (ins) req_q.push_back(cyc);
  endtask

  // Ticks numbered from the last start; every fifth one inserts a pipe column.
  task automatic run_ticks(input int from, input int to);
    for (int n = from; n <= to; n++) begin
      if (n > from) step();
      do_tick((n % 5) == 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    start = 1'b0; tick = 1'b0; bird_row = 4'd5; reset = 1'b1;
    set_pat(P);
    step();
    push("reset", P, 16'h0000, S_IDLE, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    step();
    do_tick(0);
    push("idle_tick", P, 16'h0000, S_IDLE, 0, 0, 0, 0, 0);
    step();

    // New game, then the first pipe arrives on tick 5.
    pulse_start();
    push("start", P, 16'h0000, S_GAP, 0, 0, 0, 0, 0);
    step();
    run_ticks(1, 4);
    push("gap4", P, 16'h0000, S_INS, 0, 0, 0, 0, 0);
    step();
    run_ticks(5, 5);
    push("insert1", P, 16'h0001, S_GAP, 0, 0, 0, 0, 0);
    step();
    run_ticks(6, 17);
    push("pipe_col12", P, 16'h1084, S_GAP, 0, 0, 0, 1, 4'd4);
    step();
    run_ticks(18, 18);
    push("score1", P, 16'h2108, S_GAP, 0, 1, 1, 0, 0);
    step();

    // Bird in a pipe row: hit, and the back-to-back tick is suppressed.
    pulse_start();
    push("restart", P, 16'h0000, S_GAP, 0, 0, 0, 0, 0);
    bird_row = 4'd0;
    step();
    run_ticks(1, 17);
    push("bird0_col12", P, 16'h1084, S_GAP, 0, 0, 0, 1, 4'd4);
    do_tick(0);
    push("hit_suppress", P, 16'h1084, S_OVER, 1, 0, 0, 1, 4'd4);
    step();
    do_tick(0);
    push("over_tick", P, 16'h1084, S_OVER, 1, 0, 0, 1, 4'd4);
    step();

    // start and tick together in OVER: start wins, spacing counter reloaded.
    start = 1'b1; tick = 1'b1;
    step();
    start = 1'b0; tick = 1'b0;
    push("start_tick_over", P, 16'h0000, S_GAP, 0, 0, 0, 0, 0);
    bird_row = 4'd5;
    step();
    run_ticks(1, 4);
    push("gap_reload", P, 16'h0000, S_INS, 0, 0, 0, 0, 0);
    step();
    run_ticks(5, 5);
    push("insert_restart", P, 16'h0001, S_GAP, 0, 0, 0, 0, 0);
    step();

    // All-ones pipe column: valid with gap_row 0, and the bird must hit.
    set_pat(16'hFFFF);
    pulse_start();
    step();
    run_ticks(1, 17);
    push("allones_col12", 16'hFFFF, 16'h1084, S_GAP, 0, 0, 0, 1, 4'd0);
    step();
    push("allones_hit", 16'hFFFF, 16'h1084, S_OVER, 1, 0, 0, 1, 4'd0);
    step();

    // Gap in the top row only, bird flying through it.
    set_pat(16'h7FFF);
    bird_row = 4'd15;
    pulse_start();
    step();
    run_ticks(1, 17);
    push("gap15_col12", 16'h7FFF, 16'h1084, S_GAP, 0, 0, 0, 1, 4'd15);
    step();
    push("gap15_pass", 16'h7FFF, 16'h1084, S_GAP, 0, 0, 0, 1, 4'd15);
    step();

    // Four pipes passed: 8-bit score reaches 4, 2-bit score saturates at 3.
    set_pat(P);
    bird_row = 4'd5;
    pulse_start();
    step();
    run_ticks(1, 23);
    push("score_two", P, 16'h2108, S_GAP, 0, 2, 2, 0, 0);
    step();
    run_ticks(24, 33);
    push("score_sat", P, 16'h2108, S_GAP, 0, 4, 3, 0, 0);
    step();
    run_ticks(34, 34);
    step();

    // Insertion tick then reset while tick is still high: no pipe_req survives.
    tick = 1'b1;
    step();
    reset = 1'b1;
    push("async_reset", P, 16'h0000, S_IDLE, 0, 0, 0, 0, 0);
    step();
    tick = 1'b0;
    push("reset_held", P, 16'h0000, S_IDLE, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step();
    push("after_reset", P, 16'h0000, S_IDLE, 0, 0, 0, 0, 0);

    repeat (3) step();
    cmp("exp_q drained", exp_q.size(), 0);
    cmp("req_q drained", req_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
